// File: rtl/dungeon_player_ctrl.sv
// -----------------------------------------------------------------------------
// dungeon_player_ctrl
//
// Moves the player around the dungeon grid in response to single-cycle button
// pulses. Each in-grid move request is checked against the map ROM before it
// is committed. Every move or bump is followed by a fixed cooldown, so held
// or bouncing buttons cannot step more than once per cooldown.
//
// Ports:
//   basys_clock  : system clock
//   reset        : asynchronous, active-high reset
//   up_sp        : move-up pulse (y-1)
//   down_sp      : move-down pulse (y+1)
//   left_sp      : move-left pulse (x-1)
//   right_sp     : move-right pulse (x+1)
//   centre_sp    : respawn pulse (back to START_X/START_Y, step count cleared)
//   query_valid  : one-cycle wall lookup strobe to the map ROM
//   query_x/y    : lookup coordinate; holds the last requested target
//   wall_hit     : map ROM answer, valid the cycle after query_valid
//   player_x/y   : current player position
//   moved        : one-cycle pulse when a move is committed
//   bump         : one-cycle pulse when a move is blocked (edge or wall)
//   step_count   : committed moves since reset/respawn, saturating at 0xFFFF
//   busy         : high whenever the controller is not idle
//
// Pulse priority when several arrive together: centre > up > down > left >
// right. Pulses that arrive while busy are dropped, never queued.
// -----------------------------------------------------------------------------
module dungeon_player_ctrl #(
  parameter int GRID_W   = 12,
  parameter int GRID_H   = 8,
  parameter int X_W      = 4,
  parameter int Y_W      = 3,
  parameter int START_X  = 0,
  parameter int START_Y  = 0,
  parameter int COOLDOWN = 5000000
) (
  input  logic           basys_clock,
  input  logic           reset,
  input  logic           up_sp,
  input  logic           down_sp,
  input  logic           left_sp,
  input  logic           right_sp,
  input  logic           centre_sp,
  output logic           query_valid,
  output logic [X_W-1:0] query_x,
  output logic [Y_W-1:0] query_y,
  input  logic           wall_hit,
  output logic [X_W-1:0] player_x,
  output logic [Y_W-1:0] player_y,
  output logic           moved,
  output logic           bump,
  output logic [15:0]    step_count,
  output logic           busy
);

  // Counter only needs to reach COOLDOWN-1.
  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN - 1);
  localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_START  = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y_START  = Y_W'(START_Y);
  localparam logic [15:0]      STEP_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT,
    S_COOLDOWN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cool_cnt;

  // Decoded direction request for the current cycle (only acted on in IDLE).
  logic              move_req;
  logic              off_grid;
  logic [X_W-1:0]    tgt_x;
  logic [Y_W-1:0]    tgt_y;

  // Priority decode of the direction pulses. Centre is handled ahead of this
  // in the state machine, so it implicitly outranks every direction.
  always_comb begin
    move_req = 1'b0;
    off_grid = 1'b0;
    tgt_x    = player_x;
    tgt_y    = player_y;
    if (up_sp) begin
      move_req = 1'b1;
      off_grid = (player_y == '0);
      tgt_y    = player_y - 1'b1;
    end else if (down_sp) begin
      move_req = 1'b1;
      off_grid = (player_y == Y_MAX);
      tgt_y    = player_y + 1'b1;
    end else if (left_sp) begin
      move_req = 1'b1;
      off_grid = (player_x == '0);
      tgt_x    = player_x - 1'b1;
    end else if (right_sp) begin
      move_req = 1'b1;
      off_grid = (player_x == X_MAX);
      tgt_x    = player_x + 1'b1;
    end
  end

  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cool_cnt    <= '0;
      player_x    <= X_START;
      player_y    <= Y_START;
      query_x     <= X_START;
      query_y     <= Y_START;
      query_valid <= 1'b0;
      moved       <= 1'b0;
      bump        <= 1'b0;
      busy        <= 1'b0;
      step_count  <= '0;
    end else begin
      // Strobes are single-cycle by default.
      query_valid <= 1'b0;
      moved       <= 1'b0;
      bump        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (centre_sp) begin
            player_x   <= X_START;
            player_y   <= Y_START;
            step_count <= '0;
          end else if (move_req) begin
            busy <= 1'b1;
            if (off_grid) begin
              // Edge bump needs no lookup: go straight to cooldown.
              bump     <= 1'b1;
              cool_cnt <= CNT_LOAD;
              state    <= S_COOLDOWN;
            end else begin
              query_x     <= tgt_x;
              query_y     <= tgt_y;
              query_valid <= 1'b1;
              state       <= S_QUERY;
            end
          end
        end

        S_QUERY: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          // query_x/query_y still hold the target, so they double as the
          // committed position.
          if (wall_hit) begin
            bump <= 1'b1;
          end else begin
            moved    <= 1'b1;
            player_x <= query_x;
            player_y <= query_y;
            if (step_count != STEP_MAX) begin
              step_count <= step_count + 16'd1;
            end
          end
          cool_cnt <= CNT_LOAD;
          state    <= S_COOLDOWN;
        end

        S_COOLDOWN: begin
          if (cool_cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cool_cnt <= cool_cnt - 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
